// File: rtl/spc_reg_unit_if.sv
// spc_reg_unit_if: control/status bundle between decode and the SP/PC unit.
// Shadow signals are always present; with SPC_SHADOW_EN undefined the unit
// ignores shd_save/shd_restore and ties shd_valid low.
interface spc_reg_unit_if #(
    parameter int WIDTH = 16
);
    logic             pc_en;
    logic             pc_load;
    logic [WIDTH-1:0] pc_val;
    logic [1:0]       sp_op;
    logic [WIDTH-1:0] sp_val;
    logic [1:0]       rd_sel;
    logic             fault_clr;
    logic             shd_save;
    logic             shd_restore;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] sp;
    logic [WIDTH-1:0] pc;
    logic             ovf;
    logic             udf;
    logic             faulted;
    logic             shd_valid;

    // control side (decode/test driver)
    modport master (
        output pc_en, pc_load, pc_val, sp_op, sp_val, rd_sel, fault_clr,
               shd_save, shd_restore,
        input  out, sp, pc, ovf, udf, faulted, shd_valid
    );

    // register unit side
    modport slave (
        input  pc_en, pc_load, pc_val, sp_op, sp_val, rd_sel, fault_clr,
               shd_save, shd_restore,
        output out, sp, pc, ovf, udf, faulted, shd_valid
    );
endinterface

// File: rtl/spc_reg_unit.sv
// spc_reg_unit: architectural SP/PC registers with link capture, bounds-checked
// push/pop, a sticky RUN/FAULT machine and a zero-latency read port.
// Optional macro SPC_SHADOW_EN adds a shadow SP/PC pair (save/restore).
module spc_reg_unit #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] PC_RESET    = '0,
    parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(16'hFFFE),
    parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(16'h8000),
    parameter int               SP_STEP     = 2,
    parameter int               PC_STEP     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spc_reg_unit_if.slave    bus
);

    typedef enum logic {RUN, FAULT} state_e;

    localparam logic [WIDTH-1:0] SP_STEP_W = WIDTH'(SP_STEP);
    localparam logic [WIDTH-1:0] PC_STEP_W = WIDTH'(PC_STEP);
    // bounds are compared one bit wider so LIMIT+STEP / SP+STEP cannot wrap
    localparam logic [WIDTH:0]   PUSH_MIN  = {1'b0, STACK_LIMIT} + (WIDTH+1)'(SP_STEP);
    localparam logic [WIDTH:0]   POP_MAX   = {1'b0, STACK_BASE};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sp_q, sp_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] link_q, link_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push_flt, pop_flt;

    assign push_flt = {1'b0, sp_q} < PUSH_MIN;
    assign pop_flt  = ({1'b0, sp_q} + (WIDTH+1)'(SP_STEP)) > POP_MAX;

`ifdef SPC_SHADOW_EN
    logic [WIDTH-1:0] shd_sp_q, shd_sp_d;
    logic [WIDTH-1:0] shd_pc_q, shd_pc_d;
    logic             shd_vld_q, shd_vld_d;
    logic             restore_go;

    // a restore only takes effect when a snapshot is held
    assign restore_go = bus.shd_restore & shd_vld_q;
`else
    logic shd_unused;
    assign shd_unused = bus.shd_save ^ bus.shd_restore;
`endif

    // state register: FSM, SP/PC/link, sticky flags (and shadow when enabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            sp_q    <= STACK_BASE;
            pc_q    <= PC_RESET;
            link_q  <= PC_RESET;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`ifdef SPC_SHADOW_EN
            shd_sp_q  <= STACK_BASE;
            shd_pc_q  <= PC_RESET;
            shd_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`ifdef SPC_SHADOW_EN
            shd_sp_q  <= shd_sp_d;
            shd_pc_q  <= shd_pc_d;
            shd_vld_q <= shd_vld_d;
`endif
        end
    end

    // next-state: PC and SP paths are independent; FAULT freezes both
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        pc_d    = pc_q;
        link_d  = link_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
`ifdef SPC_SHADOW_EN
        shd_sp_d  = shd_sp_q;
        shd_pc_d  = shd_pc_q;
        shd_vld_d = shd_vld_q;
`endif
        case (state_q)
            RUN: begin
                if (bus.fault_clr) begin
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
                end
                if (bus.pc_load) begin
                    link_d = pc_q;
                    pc_d   = bus.pc_val;
                end else if (bus.pc_en) begin
                    pc_d = pc_q + PC_STEP_W;
                end
                case (bus.sp_op)
                    2'b01: begin
                        if (push_flt) begin
                            ovf_d   = 1'b1;
                            state_d = FAULT;
                        end else begin
                            sp_d = sp_q - SP_STEP_W;
                        end
                    end
                    2'b10: begin
                        if (pop_flt) begin
                            udf_d   = 1'b1;
                            state_d = FAULT;
                        end else begin
                            sp_d = sp_q + SP_STEP_W;
                        end
                    end
                    2'b11:   sp_d = bus.sp_val;
                    default: ;
                endcase
            end
            FAULT: begin
                // ops presented alongside fault_clr are dropped
                if (bus.fault_clr) begin
                    state_d = RUN;
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
`ifdef SPC_SHADOW_EN
        // restore overrides everything, including a same-cycle save
        if (restore_go) begin
            state_d   = RUN;
            sp_d      = shd_sp_q;
            pc_d      = shd_pc_q;
            link_d    = link_q;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
            shd_vld_d = 1'b0;
        end else if (bus.shd_save) begin
            shd_sp_d  = sp_q;
            shd_pc_d  = pc_q;
            shd_vld_d = 1'b1;
        end
`endif
    end

    // read port: combinational from pre-edge registers
    always_comb begin
        bus.out = sp_q;
        case (bus.rd_sel)
            2'b00: bus.out = sp_q;
            2'b01: bus.out = pc_q;
            2'b10: bus.out = pc_q + PC_STEP_W;
            2'b11: bus.out = link_q;
            default: ;
        endcase
    end

    assign bus.sp      = sp_q;
    assign bus.pc      = pc_q;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;
    assign bus.faulted = (state_q == FAULT);
`ifdef SPC_SHADOW_EN
    assign bus.shd_valid = shd_vld_q;
`else
    assign bus.shd_valid = 1'b0;
`endif

endmodule
